csr_counter: RTL and testbench

CSR_COUNTER -- requirements
Module: csr_counter

---
 rtl/csr_counter_pkg.sv | 43 ++++
 rtl/mcounter_cell.sv | 49 ++++
 rtl/csr_counter.sv | 165 ++++++++++++++++
 tb/tb_csr_counter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_counter_pkg.sv
// csr_counter_pkg
// Shared definitions for the machine counter/CSR block: CSR address map,
// mhpmevent encoding width, decoded address regions and a helper that builds
// the mask of implemented counter indices.
package csr_counter_pkg;

   localparam int EVT_W     = 8;
   localparam int FIRST_HPM = 3;

   localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
   localparam logic [11:0] CSR_MHPMEVENT_BASE = 12'h320;
   localparam logic [11:0] CSR_MCOUNTER_BASE  = 12'hB00;
   localparam logic [11:0] CSR_MCOUNTERH_BASE = 12'hB80;
   localparam logic [11:0] CSR_COUNTER_BASE   = 12'hC00;
   localparam logic [11:0] CSR_COUNTERH_BASE  = 12'hC80;
   localparam logic [11:0] CSR_MCNTOVF        = 12'h7C0;
   localparam logic [11:0] CSR_MCNTOVFEN      = 12'h7C1;

   // Index 1 of the counter window is the time CSR, which lives elsewhere.
   localparam logic [4:0] IDX_TIME = 5'd1;

   typedef enum logic [2:0] {
      RGN_NONE,
      RGN_INHIBIT,
      RGN_EVENT,
      RGN_CNT_LO,
      RGN_CNT_HI,
      RGN_OVF,
      RGN_OVFEN
   } csr_region_e;

   // Bit k set when counter index k exists: mcycle (0), minstret (2) and
   // mhpmcounter3..(3+num_hpm-1).
   function automatic logic [31:0] counter_mask(input int num_hpm);
      logic [31:0] m;
      m = 32'h0000_0005;
      for (int k = FIRST_HPM; k < 32; k++) begin
         if (k < FIRST_HPM + num_hpm) m[k] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/mcounter_cell.sv
// mcounter_cell
// One hardware performance counter of CNT_W bits, written by CSR halves.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_lo, wr_hi    replace bits [XLEN-1:0] / [CNT_W-1:XLEN] with wr_data
//   wr_data         CSR write value
//   inc             count enable for this cycle
//   count           current counter value
//   ovf             high when this edge wraps the counter from all-ones to 0
module mcounter_cell
   import csr_counter_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic [XLEN-1:0]  wr_data,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   // When CNT_W equals XLEN the hi mask is empty, so hi writes fall away.
   localparam logic [CNT_W-1:0] LO_MASK = CNT_W'({XLEN{1'b1}});

   logic [CNT_W-1:0] wr_ext;
   logic [CNT_W-1:0] next_count;

   assign wr_ext = CNT_W'(wr_data);

   // A software write to either half suppresses the increment entirely.
   always_comb begin
      next_count = count;
      if (wr_lo) next_count = (next_count & ~LO_MASK) | (wr_ext & LO_MASK);
      if (wr_hi) next_count = (next_count & LO_MASK) | ((wr_ext << XLEN) & ~LO_MASK);
      if (!wr_lo && !wr_hi && inc) next_count = count + CNT_W'(1);
   end

   assign ovf = inc && !wr_lo && !wr_hi && (&count);

   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else     count <= next_count;
   end

endmodule

// File: rtl/csr_counter.sv
// csr_counter
// Machine counter CSR block: mcycle, minstret, mhpmcounter3..31 with their
// event selectors, mcountinhibit, and the custom overflow status/enable CSRs
// mcntovf / mcntovfen driving a level overflow interrupt.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   csr_write/set/clear/read          CSR operation strobes
//   csr_info                          rs1/imm operand
//   csr_addr                          CSR address
//   csr_read_data                     combinational read data
//   csr_hit                           address belongs to this block
//   instret_inc                       one instruction retired this cycle
//   hpm_event                         per-cycle event pulses
//   ovf_irq                           |(mcntovf & mcntovfen)
module csr_counter
   import csr_counter_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int CNT_W   = 64,
   parameter int NUM_HPM = 4,
   parameter int NUM_EVT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_write,
   input  logic               csr_set,
   input  logic               csr_clear,
   input  logic               csr_read,
   input  logic [XLEN-1:0]    csr_info,
   input  logic [11:0]        csr_addr,
   output logic [XLEN-1:0]    csr_read_data,
   output logic               csr_hit,
   input  logic               instret_inc,
   input  logic [NUM_EVT-1:0] hpm_event,
   output logic               ovf_irq
);

   localparam logic [31:0] CNT_MASK = counter_mask(NUM_HPM);

   csr_region_e      region;
   logic             shadow;
   logic [4:0]       idx;
   logic             wr_en;
   logic [XLEN-1:0]  wdata;
   logic [31:0]      wr_lo_vec;
   logic [31:0]      wr_hi_vec;
   logic [31:0]      cnt_inc;
   logic [31:0]      ovf_vec;
   logic [CNT_W-1:0] count_arr [32];

   logic [31:0]      mcountinhibit;
   logic [31:0]      mcntovf;
   logic [31:0]      mcntovfen;
   logic [EVT_W-1:0] mhpmevent [32];

   // Reads are purely combinational, so the read strobe carries no function.
   logic unused_sink;
   assign unused_sink = ^{csr_read, wr_lo_vec, wr_hi_vec, cnt_inc};

   assign idx = csr_addr[4:0];

   // Address decode. Shadow (0xCxx) addresses alias the counters read-only;
   // hi halves exist only for a 32-bit CSR width.
   always_comb begin
      region = RGN_NONE;
      shadow = 1'b0;
      if (csr_addr == CSR_MCOUNTINHIBIT) region = RGN_INHIBIT;
      else if (csr_addr == CSR_MCNTOVF) region = RGN_OVF;
      else if (csr_addr == CSR_MCNTOVFEN) region = RGN_OVFEN;
      else if (csr_addr[11:5] == CSR_MHPMEVENT_BASE[11:5]) begin
         if (idx >= 5'(FIRST_HPM)) region = RGN_EVENT;
      end
      else if (idx != IDX_TIME) begin
         if (csr_addr[11:5] == CSR_MCOUNTER_BASE[11:5]) region = RGN_CNT_LO;
         else if (csr_addr[11:5] == CSR_COUNTER_BASE[11:5]) begin
            region = RGN_CNT_LO;
            shadow = 1'b1;
         end
         else if (XLEN == 32 && csr_addr[11:5] == CSR_MCOUNTERH_BASE[11:5]) region = RGN_CNT_HI;
         else if (XLEN == 32 && csr_addr[11:5] == CSR_COUNTERH_BASE[11:5]) begin
            region = RGN_CNT_HI;
            shadow = 1'b1;
         end
      end
   end

   // Unimplemented counters and event selectors are tied to zero below,
   // so they read zero here without a separate check.
   always_comb begin
      csr_hit = (region != RGN_NONE);
      case (region)
         RGN_INHIBIT: csr_read_data = XLEN'(mcountinhibit);
         RGN_OVF:     csr_read_data = XLEN'(mcntovf);
         RGN_OVFEN:   csr_read_data = XLEN'(mcntovfen);
         RGN_EVENT:   csr_read_data = XLEN'(mhpmevent[idx]);
         RGN_CNT_LO:  csr_read_data = XLEN'(count_arr[idx]);
         RGN_CNT_HI:  csr_read_data = XLEN'(count_arr[idx] >> XLEN);
         default:     csr_read_data = '0;
      endcase
   end

   // Set/clear are read-modify-write against the current read value.
   always_comb begin
      if (csr_set)        wdata = csr_info | csr_read_data;
      else if (csr_clear) wdata = ~csr_info & csr_read_data;
      else                wdata = csr_info;
   end

   assign wr_en     = (csr_write || csr_set || csr_clear) && !shadow;
   assign wr_lo_vec = (wr_en && region == RGN_CNT_LO) ? (32'd1 << idx) : 32'd0;
   assign wr_hi_vec = (wr_en && region == RGN_CNT_HI) ? (32'd1 << idx) : 32'd0;

   // Event codes 1..NUM_EVT pick hpm_event[code-1]; 0 and larger codes never count.
   always_comb begin
      logic evt_sel;
      cnt_inc    = '0;
      cnt_inc[0] = ~mcountinhibit[0];
      cnt_inc[2] = instret_inc & ~mcountinhibit[2];
      for (int k = FIRST_HPM; k < 32; k++) begin
         evt_sel = 1'b0;
         for (int j = 0; j < NUM_EVT; j++) begin
            if (mhpmevent[k] == EVT_W'(j + 1)) evt_sel = hpm_event[j];
         end
         cnt_inc[k] = CNT_MASK[k] & evt_sel & ~mcountinhibit[k];
      end
   end

   for (genvar g = 0; g < 32; g++) begin : g_cnt
      if (CNT_MASK[g]) begin : g_cell
         mcounter_cell #(.XLEN(XLEN), .CNT_W(CNT_W)) u_cell (
            .clk     (clk),
            .rst     (rst),
            .wr_lo   (wr_lo_vec[g]),
            .wr_hi   (wr_hi_vec[g]),
            .wr_data (wdata),
            .inc     (cnt_inc[g]),
            .count   (count_arr[g]),
            .ovf     (ovf_vec[g])
         );
      end else begin : g_none
         assign count_arr[g] = '0;
         assign ovf_vec[g]   = 1'b0;
      end
   end

   // Hardware overflow sets are OR-ed after the software value so they win
   // over a same-cycle write clearing that bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcountinhibit <= '0;
         mcntovf       <= '0;
         mcntovfen     <= '0;
         for (int k = 0; k < 32; k++) mhpmevent[k] <= '0;
      end else begin
         if (wr_en && region == RGN_INHIBIT) mcountinhibit <= wdata[31:0] & CNT_MASK;
         if (wr_en && region == RGN_OVFEN)   mcntovfen     <= wdata[31:0] & CNT_MASK;
         mcntovf <= ((wr_en && region == RGN_OVF) ? (wdata[31:0] & CNT_MASK) : mcntovf)
                    | (ovf_vec & CNT_MASK);
         if (wr_en && region == RGN_EVENT && CNT_MASK[idx]) mhpmevent[idx] <= wdata[EVT_W-1:0];
      end
   end

   assign ovf_irq = |(mcntovf & mcntovfen);

endmodule

// File: tb/tb_csr_counter.sv
// tb_csr_counter
// Directed bench for csr_counter (XLEN=32, CNT_W=64, NUM_HPM=4, NUM_EVT=8).
// Expected CSR reads are queued as each step is driven and drained by
// checkOutput, which compares read data and hit flag.
module tb_csr_counter;

   localparam int OP_WRITE = 0;
   localparam int OP_SET   = 1;
   localparam int OP_CLEAR = 2;

   typedef struct {
      string       tag;
      logic [11:0] addr;
      logic [31:0] data;
      logic        hit;
   } expect_t;

   expect_t scoreboard [$];
   int checks = 0;
   int errors = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csr_write = 1'b0;
   logic        csr_set = 1'b0;
   logic        csr_clear = 1'b0;
   logic        csr_read = 1'b0;
   logic [31:0] csr_info = '0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_read_data;
   logic        csr_hit;
   logic        instret_inc = 1'b0;
   logic [7:0]  hpm_event = '0;
   logic        ovf_irq;

   csr_counter #(.XLEN(32), .CNT_W(64), .NUM_HPM(4), .NUM_EVT(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .csr_write     (csr_write),
      .csr_set       (csr_set),
      .csr_clear     (csr_clear),
      .csr_read      (csr_read),
      .csr_info      (csr_info),
      .csr_addr      (csr_addr),
      .csr_read_data (csr_read_data),
      .csr_hit       (csr_hit),
      .instret_inc   (instret_inc),
      .hpm_event     (hpm_event),
      .ovf_irq       (ovf_irq)
   );

   always #10 clk = ~clk;

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One CSR operation held across exactly one rising edge.
   task automatic applyStimulus(input int op, input logic [11:0] addr, input logic [31:0] data);
      csr_addr  = addr;
      csr_info  = data;
      csr_write = (op == OP_WRITE);
      csr_set   = (op == OP_SET);
      csr_clear = (op == OP_CLEAR);
      @(posedge clk);
      #1;
      csr_write = 1'b0;
      csr_set   = 1'b0;
      csr_clear = 1'b0;
   endtask

   task automatic expectRead(input string tag, input logic [11:0] addr,
                             input logic [31:0] data, input logic hit);
      expect_t e;
      e.tag  = tag;
      e.addr = addr;
      e.data = data;
      e.hit  = hit;
      scoreboard.push_back(e);
   endtask

   task automatic checkOutput();
      expect_t e;
      while (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         csr_addr = e.addr;
         csr_read = 1'b1;
         #1;
         checks++;
         assert (csr_read_data === e.data) else begin
            errors++;
            $error("[TB] FAIL %s: read_data observed 0x%h expected 0x%h", e.tag, csr_read_data, e.data);
         end
         checks++;
         assert (csr_hit === e.hit) else begin
            errors++;
            $error("[TB] FAIL %s_hit: csr_hit observed %b expected %b", e.tag, csr_hit, e.hit);
         end
         csr_read = 1'b0;
      end
   endtask

   task automatic checkIrq(input string tag, input logic exp);
      checks++;
      assert (ovf_irq === exp) else begin
         errors++;
         $error("[TB] FAIL %s: ovf_irq observed %b expected %b", tag, ovf_irq, exp);
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expectRead("rst_mcycle", 12'hB00, 32'h0, 1'b1);
      expectRead("rst_minstret", 12'hB02, 32'h0, 1'b1);
      expectRead("rst_inhibit", 12'h320, 32'h0, 1'b1);
      expectRead("rst_ovf", 12'h7C0, 32'h0, 1'b1);
      expectRead("rst_ovfen", 12'h7C1, 32'h0, 1'b1);
      expectRead("rst_evt3", 12'h323, 32'h0, 1'b1);
      checkOutput();
      checkIrq("rst_irq", 1'b0);

      // Free-running mcycle over 10 idle cycles
      idle(10);
      expectRead("idle_mcycle", 12'hB00, 32'd10, 1'b1);
      expectRead("idle_cycle", 12'hC00, 32'd10, 1'b1);
      expectRead("idle_mcycleh", 12'hB80, 32'd0, 1'b1);
      expectRead("idle_minstret", 12'hB02, 32'd0, 1'b1);
      expectRead("idle_instret", 12'hC02, 32'd0, 1'b1);
      checkOutput();
      checkIrq("idle_irq", 1'b0);

      // Carry from lo into hi half
      applyStimulus(OP_WRITE, 12'hB00, 32'hFFFF_FFFF);
      applyStimulus(OP_WRITE, 12'hB80, 32'h0);
      idle(2);
      expectRead("carry_hi", 12'hB80, 32'd1, 1'b1);
      expectRead("carry_lo", 12'hB00, 32'd1, 1'b1);
      expectRead("carry_shadow_hi", 12'hC80, 32'd1, 1'b1);
      expectRead("carry_shadow_lo", 12'hC00, 32'd1, 1'b1);
      expectRead("carry_ovf", 12'h7C0, 32'd0, 1'b1);
      checkOutput();

      // HPM3 wrap on event 2
      applyStimulus(OP_WRITE, 12'h323, 32'h0000_01FF);
      expectRead("evt_lowbyte", 12'h323, 32'h0000_00FF, 1'b1);
      checkOutput();
      applyStimulus(OP_WRITE, 12'hB03, 32'hFFFF_FFFF);
      applyStimulus(OP_WRITE, 12'hB83, 32'hFFFF_FFFF);
      applyStimulus(OP_WRITE, 12'h323, 32'd2);
      applyStimulus(OP_SET, 12'h7C1, 32'h8);
      expectRead("hpm3_lo_ones", 12'hB03, 32'hFFFF_FFFF, 1'b1);
      expectRead("hpm3_hi_ones", 12'hB83, 32'hFFFF_FFFF, 1'b1);
      expectRead("evt3_two", 12'h323, 32'd2, 1'b1);
      checkOutput();
      checkIrq("pre_wrap_irq", 1'b0);
      hpm_event = 8'h02;
      @(posedge clk);
      #1;
      hpm_event = 8'h00;
      expectRead("wrap_lo", 12'hB03, 32'h0, 1'b1);
      expectRead("wrap_hi", 12'hB83, 32'h0, 1'b1);
      expectRead("wrap_shadow", 12'hC03, 32'h0, 1'b1);
      expectRead("wrap_ovf", 12'h7C0, 32'h8, 1'b1);
      expectRead("wrap_ovfen", 12'h7C1, 32'h8, 1'b1);
      checkOutput();
      checkIrq("wrap_irq", 1'b1);
      hpm_event = 8'h01;
      @(posedge clk);
      #1;
      hpm_event = 8'h00;
      expectRead("other_event", 12'hB03, 32'h0, 1'b1);
      checkOutput();
      applyStimulus(OP_CLEAR, 12'h7C0, 32'h8);
      expectRead("ovf_cleared", 12'h7C0, 32'h0, 1'b1);
      checkOutput();
      checkIrq("cleared_irq", 1'b0);

      // mcountinhibit masking and inhibit behaviour
      applyStimulus(OP_WRITE, 12'h320, 32'hFFFF_FFFF);
      expectRead("inhibit_mask", 12'h320, 32'h0000_007D, 1'b1);
      checkOutput();
      applyStimulus(OP_WRITE, 12'h320, 32'h5);
      applyStimulus(OP_WRITE, 12'hB02, 32'h55);
      applyStimulus(OP_WRITE, 12'hB00, 32'h100);
      applyStimulus(OP_WRITE, 12'hB80, 32'h0);
      instret_inc = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      instret_inc = 1'b0;
      expectRead("inh_inhibit", 12'h320, 32'h5, 1'b1);
      expectRead("inh_mcycle", 12'hB00, 32'h100, 1'b1);
      expectRead("inh_mcycleh", 12'hB80, 32'h0, 1'b1);
      expectRead("inh_minstret", 12'hB02, 32'h55, 1'b1);
      checkOutput();
      applyStimulus(OP_CLEAR, 12'h320, 32'h1);
      idle(3);
      expectRead("uninh_mcycle", 12'hB00, 32'h103, 1'b1);
      expectRead("uninh_inhibit", 12'h320, 32'h4, 1'b1);
      expectRead("uninh_minstret", 12'hB02, 32'h55, 1'b1);
      checkOutput();

      // Write beats same-cycle increment on minstret
      applyStimulus(OP_WRITE, 12'h320, 32'h0);
      csr_addr    = 12'hB02;
      csr_info    = 32'h1234;
      csr_write   = 1'b1;
      instret_inc = 1'b1;
      @(posedge clk);
      #1;
      csr_write = 1'b0;
      expectRead("wr_prio", 12'hB02, 32'h1234, 1'b1);
      checkOutput();
      @(posedge clk);
      #1;
      instret_inc = 1'b0;
      expectRead("instret_inc", 12'hB02, 32'h1235, 1'b1);
      expectRead("instret_hi", 12'hB82, 32'h0, 1'b1);
      checkOutput();

      // Shadow read-only, decode holes, unimplemented HPM
      applyStimulus(OP_SET, 12'h320, 32'h1);
      applyStimulus(OP_WRITE, 12'hB00, 32'h200);
      applyStimulus(OP_WRITE, 12'hB80, 32'h0);
      applyStimulus(OP_WRITE, 12'hC00, 32'hDEAD);
      applyStimulus(OP_WRITE, 12'hB1F, 32'hABC);
      applyStimulus(OP_WRITE, 12'hB06, 32'h77);
      applyStimulus(OP_WRITE, 12'hB07, 32'h55);
      applyStimulus(OP_WRITE, 12'h327, 32'h3);
      expectRead("shadow_ro", 12'hB00, 32'h200, 1'b1);
      expectRead("shadow_rd", 12'hC00, 32'h200, 1'b1);
      expectRead("time_lo", 12'hB01, 32'h0, 1'b0);
      expectRead("time_hi", 12'hB81, 32'h0, 1'b0);
      expectRead("time_sh", 12'hC01, 32'h0, 1'b0);
      expectRead("time_shh", 12'hC81, 32'h0, 1'b0);
      expectRead("evt_hole", 12'h321, 32'h0, 1'b0);
      expectRead("hpm31", 12'hB1F, 32'h0, 1'b1);
      expectRead("hpm6", 12'hB06, 32'h77, 1'b1);
      expectRead("hpm6_sh", 12'hC06, 32'h77, 1'b1);
      expectRead("hpm7", 12'hB07, 32'h0, 1'b1);
      expectRead("evt7", 12'h327, 32'h0, 1'b1);
      checkOutput();

      // Reset dominates a same-cycle write and increment
      applyStimulus(OP_WRITE, 12'h320, 32'h0);
      applyStimulus(OP_WRITE, 12'h7C0, 32'h8);
      checkIrq("pre_rst_irq", 1'b1);
      csr_addr    = 12'hB06;
      csr_info    = 32'h99;
      csr_write   = 1'b1;
      instret_inc = 1'b1;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      csr_write   = 1'b0;
      instret_inc = 1'b0;
      expectRead("rst2_hpm6", 12'hB06, 32'h0, 1'b1);
      expectRead("rst2_mcycle", 12'hB00, 32'h0, 1'b1);
      expectRead("rst2_minstret", 12'hB02, 32'h0, 1'b1);
      expectRead("rst2_ovf", 12'h7C0, 32'h0, 1'b1);
      expectRead("rst2_ovfen", 12'h7C1, 32'h0, 1'b1);
      expectRead("rst2_evt3", 12'h323, 32'h0, 1'b1);
      checkOutput();
      checkIrq("rst2_irq", 1'b0);
      idle(1);
      expectRead("rst2_mcycle_run", 12'hB00, 32'h1, 1'b1);
      checkOutput();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
